// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters; strobes one cycle after grant, ready one cycle after mem_ready.
// Requesters hold until their ready pulse; data wins unless fetch has waited MAX_RUN data grants.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MAX_RUN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              imem_req,
   input  logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_rdata,
   output logic              imem_ready,
   input  logic              dmem_re,
   input  logic              dmem_wr,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [DATA_W-1:0] dmem_wdata,
   output logic [DATA_W-1:0] dmem_rdata,
   output logic              dmem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [1:0]        owner
);

   localparam int RUN_W = $clog2(MAX_RUN + 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      IMEM = 2'b01,
      DMEM = 2'b10
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [RUN_W-1:0] run_cnt;
   logic             dreq;
   logic             run_ok;
   logic             grant_i;
   logic             grant_d;
   logic             done;

   assign dreq   = dmem_re | dmem_wr;
   // Data may only jump ahead of a waiting fetch while its run budget lasts.
   assign run_ok = !imem_req || (run_cnt < RUN_W'(MAX_RUN));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (dreq && run_ok) begin
               state_nxt = DMEM;
            end else if (imem_req) begin
               state_nxt = IMEM;
            end
         end
         IMEM, DMEM: begin
            if (mem_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant_i = (state == IDLE) && (state_nxt == IMEM);
      grant_d = (state == IDLE) && (state_nxt == DMEM);
      done    = (state != IDLE) && mem_ready;
      owner   = state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt    <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_re     <= 1'b0;
         mem_wr     <= 1'b0;
         imem_rdata <= '0;
         dmem_rdata <= '0;
         imem_ready <= 1'b0;
         dmem_ready <= 1'b0;
      end else begin
         imem_ready <= done && (state == IMEM);
         dmem_ready <= done && (state == DMEM);

         if (grant_i) begin
            mem_addr  <= imem_addr;
            mem_wdata <= '0;
            mem_re    <= 1'b1;
            mem_wr    <= 1'b0;
            run_cnt   <= '0;
         end else if (grant_d) begin
            mem_addr  <= dmem_addr;
            mem_wdata <= dmem_wdata;
            // A request with both strobes set is a write.
            mem_wr    <= dmem_wr;
            mem_re    <= !dmem_wr;
            if (!imem_req) begin
               run_cnt <= '0;
            end else if (run_cnt != RUN_W'(MAX_RUN)) begin
               run_cnt <= run_cnt + 1'b1;
            end
         end else if (done) begin
            mem_re <= 1'b0;
            mem_wr <= 1'b0;
            if (state == IMEM) begin
               imem_rdata <= mem_rdata;
            end else if (mem_re) begin
               dmem_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then randomized traffic, all compared
// cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MR = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_rdata;
   logic          imem_ready;
   logic          dmem_re;
   logic          dmem_wr;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic [DW-1:0] dmem_rdata;
   logic          dmem_ready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_re;
   logic          mem_wr;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic [1:0]    owner;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_RUN(MR)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .dmem_re(dmem_re), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner)
   );

   int total = 0;
   int bad   = 0;

   // reference model: who owns the port, pending fetch-skip budget, expected outputs
   int            m_owner;
   int            m_run;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_irdata;
   logic [DW-1:0] m_drdata;
   logic          m_re, m_wr, m_iready, m_dready;

   int   grants[$];
   logic rec = 1'b0;
   logic [1:0] prev_owner = 2'b00;
   int   ip, dp, rp;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         m_owner = 0; m_run = 0; m_addr = '0; m_wdata = '0;
         m_re = 0; m_wr = 0; m_iready = 0; m_dready = 0; m_irdata = '0; m_drdata = '0;
      end else begin
         m_iready = 0;
         m_dready = 0;
         if (m_owner == 0) begin
            if ((dmem_re || dmem_wr) && (!imem_req || m_run < MR)) begin
               m_owner = 2; m_addr = dmem_addr; m_wdata = dmem_wdata;
               m_wr = dmem_wr; m_re = !dmem_wr;
               m_run = imem_req ? ((m_run + 1 > MR) ? MR : m_run + 1) : 0;
            end else if (imem_req) begin
               m_owner = 1; m_addr = imem_addr; m_re = 1; m_wr = 0; m_run = 0;
            end
         end else if (mem_ready) begin
            if (m_owner == 1) begin
               m_iready = 1; m_irdata = mem_rdata;
            end else begin
               m_dready = 1;
               if (m_re) m_drdata = mem_rdata;
            end
            m_owner = 0; m_re = 0; m_wr = 0;
         end
      end
   endtask

   task automatic compare();
      chk("owner", 32'(owner), 32'(m_owner));
      chk("mem_re", 32'(mem_re), 32'(m_re));
      chk("mem_wr", 32'(mem_wr), 32'(m_wr));
      if (m_re || m_wr) chk("mem_addr", mem_addr, m_addr);
      if (m_wr) chk("mem_wdata", mem_wdata, m_wdata);
      chk("imem_ready", 32'(imem_ready), 32'(m_iready));
      chk("dmem_ready", 32'(dmem_ready), 32'(m_dready));
      chk("imem_rdata", imem_rdata, m_irdata);
      chk("dmem_rdata", dmem_rdata, m_drdata);
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      compare();
      if (rec && owner != 2'b00 && prev_owner == 2'b00) grants.push_back(int'(owner));
      prev_owner = owner;
   endtask

   // random requesters and memory responder; requesters drop a request when its ready pulses
   task automatic drive();
      int kind;
      if (imem_ready) imem_req = 1'b0;
      if (!imem_req && $urandom_range(99) < 32'(ip)) begin
         imem_req  = 1'b1;
         imem_addr = $urandom;
      end
      if (dmem_ready) begin
         dmem_re = 1'b0;
         dmem_wr = 1'b0;
      end
      if (!dmem_re && !dmem_wr && $urandom_range(99) < 32'(dp)) begin
         kind    = int'($urandom_range(2));
         dmem_re = (kind != 1);
         dmem_wr = (kind != 0);
      end
      if ($urandom_range(3) == 0) begin
         dmem_addr  = $urandom;
         dmem_wdata = $urandom;
         imem_addr  = $urandom;
      end
      if (mem_re || mem_wr) mem_ready = ($urandom_range(99) < 32'(rp));
      else                  mem_ready = ($urandom_range(99) < 20);
      mem_rdata = $urandom;
      rst = ($urandom_range(199) == 0);
   endtask

   initial begin
      rst = 1'b1; imem_req = 1'b1; imem_addr = 32'h100;
      dmem_re = 1'b1; dmem_wr = 1'b1; dmem_addr = 32'h2000; dmem_wdata = 32'h55;
      mem_rdata = '0; mem_ready = 1'b0;

      // reset with every request high, then a both-strobe request resolves as a write
      cycle(); cycle();
      chk("rst_owner", 32'(owner), 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_flags", 32'({mem_re, mem_wr, imem_ready, dmem_ready}), 32'h0);
      rst = 1'b0;
      cycle();
      chk("first_grant_dmem", 32'(owner), 32'h2);
      chk("both_is_write", 32'({mem_wr, mem_re}), 32'h2);
      chk("grant_addr", mem_addr, 32'h2000);
      chk("grant_wdata", mem_wdata, 32'h55);
      mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
      cycle();
      chk("wr_ready", 32'(dmem_ready), 32'h1);
      chk("wr_keeps_rdata", dmem_rdata, 32'h0);
      chk("wr_no_iready", 32'(imem_ready), 32'h0);

      // fetch served next, mem_ready after two strobe cycles
      dmem_re = 1'b0; dmem_wr = 1'b0; mem_ready = 1'b0;
      cycle();
      chk("fetch_grant", 32'(owner), 32'h1);
      chk("fetch_addr", mem_addr, 32'h100);
      cycle();
      chk("fetch_hold", 32'({mem_re, mem_wr}), 32'h2);
      mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
      cycle();
      chk("fetch_ready", 32'(imem_ready), 32'h1);
      chk("fetch_rdata", imem_rdata, 32'hDEADBEEF);
      imem_req = 1'b0;
      cycle();
      chk("fetch_pulse_once", 32'(imem_ready), 32'h0);
      chk("idle_ignores_ready", 32'({owner, dmem_ready}), 32'h0);

      // simultaneous fetch and plain write
      mem_ready = 1'b0; imem_req = 1'b1; imem_addr = 32'h104;
      dmem_wr = 1'b1; dmem_addr = 32'h2000; dmem_wdata = 32'h55;
      cycle();
      chk("sim_dmem_first", 32'(owner), 32'h2);
      chk("sim_write", 32'({mem_wr, mem_re}), 32'h2);
      mem_ready = 1'b1;
      cycle();
      chk("sim_dready", 32'(dmem_ready), 32'h1);
      chk("sim_keeps_rdata", dmem_rdata, 32'h0);
      dmem_wr = 1'b0; mem_ready = 1'b0;
      cycle();
      chk("sim_fetch_next", 32'(owner), 32'h1);
      mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
      cycle();
      chk("sim_iready", 32'(imem_ready), 32'h1);
      imem_req = 1'b0; mem_ready = 1'b0;
      cycle();

      // reset in the same cycle as mem_ready aborts without a ready pulse
      dmem_re = 1'b1; dmem_addr = 32'h3000;
      cycle();
      chk("mid_grant", 32'({owner, mem_re}), 32'h5);
      rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h11111111;
      cycle();
      chk("mid_no_ready", 32'(dmem_ready), 32'h0);
      chk("mid_idle", 32'(owner), 32'h0);
      chk("mid_strobes", 32'({mem_re, mem_wr}), 32'h0);
      chk("mid_no_capture", dmem_rdata, 32'h0);
      rst = 1'b0; mem_ready = 1'b0; dmem_re = 1'b0;
      cycle();

      // continuous loads against a waiting fetch: four data grants, then one fetch
      grants.delete();
      rec = 1'b1; imem_req = 1'b1; imem_addr = 32'h200; dmem_re = 1'b1; dmem_addr = 32'h4000;
      mem_ready = 1'b1;
      repeat (40) cycle();
      rec = 1'b0;
      chk("starve_count", 32'(grants.size() >= 10), 32'h1);
      for (int k = 0; k < 10 && k < grants.size(); k++)
         chk("starve_seq", 32'(grants[k]), (k % 5 == 4) ? 32'h1 : 32'h2);
      imem_req = 1'b0; dmem_re = 1'b0; mem_ready = 1'b0;

      for (int blk = 0; blk < 4; blk++) begin
         ip = (blk == 3) ? 95 : 20 + 25 * blk;
         dp = (blk == 3) ? 95 : 60 - 10 * blk;
         rp = (blk == 2) ? 100 : 40;
         repeat (600) begin
            drive();
            cycle();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
